// File: rtl/jttrack_dwnld_pkg.sv
// Shared constants, FIFO entry layout and address helpers for the download post-processor.
package jttrack_dwnld_pkg;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned PtrW      = 2;
  localparam int unsigned CntW      = 3;
  localparam int unsigned WaitThr   = 3;
  localparam int unsigned PromSize  = 2048;
  localparam int unsigned AddrW     = 21;
  localparam int unsigned MaskW     = 2;
  localparam int unsigned DataW     = 8;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [MaskW-1:0] mask;
    logic [DataW-1:0] data;
  } entry_t;

  function automatic logic in_range(input logic [21:0] a, input logic [21:0] lo,
                                    input logic [21:0] hi);
    return (a >= lo) && (a < hi);
  endfunction

  // Object ROM line reorder: a[4:0] -> {a[2:0], ~a[4], ~a[3]}
  function automatic logic [21:0] obj_swizzle(input logic [21:0] a);
    return {a[21:5], a[2:0], ~a[4], ~a[3]};
  endfunction

  // Active-low byte enables: even byte -> 2'b10, odd byte -> 2'b01
  function automatic entry_t make_entry(input logic [21:0] a, input logic [7:0] d);
    entry_t e;
    e.addr = a[21:1];
    e.mask = {~a[0], a[0]};
    e.data = d;
    return e;
  endfunction

endpackage

// File: rtl/jttrack_dwnld_fifo.sv
// Four-entry SDRAM write FIFO with count, head view and registered almost-full flag.
module jttrack_dwnld_fifo
  import jttrack_dwnld_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  entry_t          i_din,
  output entry_t          o_head,
  output logic [CntW-1:0] o_count,
  output logic [CntW-1:0] o_count_next,
  output logic            o_almost_full
);

  entry_t          r_mem [FifoDepth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_afull;
  logic            w_pop;
  logic            w_push;
  logic [CntW-1:0] w_count_d;

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  always_comb begin
    w_pop     = i_pop && (r_count != '0);
    w_push    = i_push && ((r_count != CntW'(FifoDepth)) || w_pop);
    w_count_d = r_count + CntW'(w_push) - CntW'(w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(FifoDepth); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_d;
      r_afull <= (w_count_d >= CntW'(WaitThr));
    end
  end

  assign o_head        = r_mem[r_rptr];
  assign o_count       = r_count;
  assign o_count_next  = w_count_d;
  assign o_almost_full = r_afull;

endmodule

// File: rtl/jttrack_dwnld.sv
// Track & Field download post-processor: ROM bit reordering, SDRAM write FIFO, PROM routing.
module jttrack_dwnld
  import jttrack_dwnld_pkg::*;
#(
  parameter logic [21:0] SCR_START  = 22'h0,
  parameter logic [21:0] OBJ_START  = 22'h0,
  parameter logic [21:0] PCM_START  = 22'h0,
  parameter logic [24:0] PROM_START = 25'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_downloading,
  input  logic [24:0] i_ioctl_addr,
  input  logic [7:0]  i_ioctl_dout,
  input  logic        i_ioctl_wr,
  output logic        o_ioctl_wait,
  output logic [20:0] o_prog_addr,
  output logic [15:0] o_prog_data,
  output logic [1:0]  o_prog_mask,
  output logic        o_prog_we,
  input  logic        i_prog_ack,
  output logic        o_prom_we,
  output logic [10:0] o_prom_addr,
  output logic [7:0]  o_prom_data,
  output logic        o_dwn_done,
  output logic        o_overflow
);

  logic            w_acc;
  logic            w_sdram;
  logic            w_sdram_wr;
  logic            w_prom;
  logic [24:0]     w_prom_off;
  logic [21:0]     w_a;
  logic [21:0]     w_xa;
  entry_t          w_entry;
  entry_t          w_head;
  logic [CntW-1:0] w_count;
  logic [CntW-1:0] w_count_next;
  logic            w_full;
  logic            w_ovf;
  logic            w_rise;
  logic            w_fall;
  logic            w_afull;

  logic            r_dl;
  logic            r_armed;
  logic            r_done;
  logic            r_ovf;
  logic            r_prom_we;
  logic [10:0]     r_prom_addr;
  logic [7:0]      r_prom_data;

  always_comb begin
    w_acc      = i_ioctl_wr && i_downloading;
    w_sdram    = (i_ioctl_addr < PROM_START);
    w_prom_off = i_ioctl_addr - PROM_START;
    w_prom     = !w_sdram && (w_prom_off < 25'(PromSize));
    w_sdram_wr = w_acc && w_sdram;
    w_a        = i_ioctl_addr[21:0];
    if (in_range(w_a, SCR_START, OBJ_START))      w_xa = {w_a[21:1], ~w_a[0]};
    else if (in_range(w_a, OBJ_START, PCM_START)) w_xa = obj_swizzle(w_a);
    else                                          w_xa = w_a;
    w_entry = make_entry(w_xa, i_ioctl_dout);
    w_full  = (w_count == CntW'(FifoDepth));
    w_ovf   = w_sdram_wr && w_full && !i_prog_ack;
    w_rise  = i_downloading && !r_dl;
    w_fall  = !i_downloading && r_dl;
  end

  jttrack_dwnld_fifo u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (w_sdram_wr),
    .i_pop         (i_prog_ack),
    .i_din         (w_entry),
    .o_head        (w_head),
    .o_count       (w_count),
    .o_count_next  (w_count_next),
    .o_almost_full (w_afull)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dl        <= 1'b0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_prom_we   <= 1'b0;
      r_prom_addr <= '0;
      r_prom_data <= '0;
    end else begin
      r_dl      <= i_downloading;
      r_prom_we <= w_acc && w_prom;
      if (w_acc && w_prom) begin
        r_prom_addr <= w_prom_off[10:0];
        r_prom_data <= i_ioctl_dout;
      end
      if (w_ovf)       r_ovf <= 1'b1;
      else if (w_rise) r_ovf <= 1'b0;
      // Done fires once the FIFO is empty after this cycle; a new session disarms it
      r_done <= 1'b0;
      if (w_rise) begin
        r_armed <= 1'b0;
      end else if ((r_armed || w_fall) && (w_count_next == '0) && !w_sdram_wr) begin
        r_done  <= 1'b1;
        r_armed <= 1'b0;
      end else begin
        r_armed <= r_armed || w_fall;
      end
    end
  end

  assign o_ioctl_wait = w_afull;
  assign o_prog_we    = (w_count != '0);
  assign o_prog_addr  = w_head.addr;
  assign o_prog_mask  = w_head.mask;
  assign o_prog_data  = {w_head.data, w_head.data};
  assign o_prom_we    = r_prom_we;
  assign o_prom_addr  = r_prom_addr;
  assign o_prom_data  = r_prom_data;
  assign o_dwn_done   = r_done;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_jttrack_dwnld.sv
// Directed bench for jttrack_dwnld with a scoreboard of expected SDRAM writes.
module tb_jttrack_dwnld;

  localparam logic [21:0] Scr  = 22'h10000;
  localparam logic [21:0] Obj  = 22'h20000;
  localparam logic [21:0] Pcm  = 22'h28000;
  localparam logic [24:0] Prom = 25'h30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_ack = 1'b0;
  logic        ioctl_wait;
  logic [20:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic [10:0] prom_addr;
  logic [7:0]  prom_data;
  logic        dwn_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [20:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  jttrack_dwnld #(
    .SCR_START  (Scr),
    .OBJ_START  (Obj),
    .PCM_START  (Pcm),
    .PROM_START (Prom)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_downloading (downloading),
    .i_ioctl_addr  (ioctl_addr),
    .i_ioctl_dout  (ioctl_dout),
    .i_ioctl_wr    (ioctl_wr),
    .o_ioctl_wait  (ioctl_wait),
    .o_prog_addr   (prog_addr),
    .o_prog_data   (prog_data),
    .o_prog_mask   (prog_mask),
    .o_prog_we     (prog_we),
    .i_prog_ack    (prog_ack),
    .o_prom_we     (prom_we),
    .o_prom_addr   (prom_addr),
    .o_prom_data   (prom_data),
    .o_dwn_done    (dwn_done),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  function automatic logic [21:0] tb_xlate(input logic [24:0] ad);
    logic [21:0] a;
    a = ad[21:0];
    if (a >= Scr && a < Obj)      a = a ^ 22'h1;
    else if (a >= Obj && a < Pcm) a = {a[21:5], a[2], a[1], a[0], !a[4], !a[3]};
    return a;
  endfunction

  task automatic expect_push(input logic [24:0] a, input logic [7:0] d);
    logic [21:0] x;
    exp_t e;
    x = tb_xlate(a);
    e.addr = x[21:1];
    e.mask = x[0] ? 2'b01 : 2'b10;
    e.data = {d, d};
    sb.push_back(e);
  endtask

  // Compare the presented head with the oldest expected entry, then ack it for one cycle
  task automatic ack_head(input string tag);
    exp_t e;
    check({tag, ".we"}, 32'(prog_we), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".addr"}, 32'(prog_addr), 32'(e.addr));
      check({tag, ".mask"}, 32'(prog_mask), 32'(e.mask));
      check({tag, ".data"}, 32'(prog_data), 32'(e.data));
    end
    prog_ack = 1'b1;
    step();
    prog_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst.we", 32'(prog_we), 32'd0);
    check("rst.wait", 32'(ioctl_wait), 32'd0);
    check("rst.prom_we", 32'(prom_we), 32'd0);
    check("rst.done", 32'(dwn_done), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    check("rst.addr", 32'(prog_addr), 32'd0);
    rst = 1'b0;
    step();

    // Strobes outside a session are ignored
    drive(25'h10004, 8'h99);
    step();
    ioctl_wr = 1'b0;
    check("nosess.we", 32'(prog_we), 32'd0);
    drive(25'h30001, 8'h99);
    step();
    ioctl_wr = 1'b0;
    check("nosess.prom", 32'(prom_we), 32'd0);

    downloading = 1'b1;
    step();

    // Scroll byte
    drive(25'h10004, 8'h5A);
    expect_push(25'h10004, 8'h5A);
    step();
    ioctl_wr = 1'b0;
    check("scr.we", 32'(prog_we), 32'd1);
    check("scr.addr", 32'(prog_addr), 32'h8002);
    check("scr.mask", 32'(prog_mask), 32'h1);
    check("scr.data", 32'(prog_data), 32'h5A5A);
    ack_head("scr");
    check("scr.empty", 32'(prog_we), 32'd0);

    // Object permutation
    drive(25'h20001, 8'hC3);
    expect_push(25'h20001, 8'hC3);
    step();
    ioctl_wr = 1'b0;
    check("obj.addr", 32'(prog_addr), 32'h10003);
    check("obj.mask", 32'(prog_mask), 32'h1);
    ack_head("obj");

    // Pass-through below scroll and in PCM region
    drive(25'h00006, 8'h11);
    expect_push(25'h00006, 8'h11);
    step();
    drive(25'h28003, 8'h22);
    expect_push(25'h28003, 8'h22);
    step();
    ioctl_wr = 1'b0;
    check("pass.mask_lo", 32'(prog_mask), 32'h2);
    ack_head("pass0");
    ack_head("pass1");

    // PROM routing and region ends
    drive(25'h30105, 8'h3C);
    step();
    ioctl_wr = 1'b0;
    check("prom.we", 32'(prom_we), 32'd1);
    check("prom.addr", 32'(prom_addr), 32'h105);
    check("prom.data", 32'(prom_data), 32'h3C);
    check("prom.nosdram", 32'(prog_we), 32'd0);
    step();
    check("prom.pulse", 32'(prom_we), 32'd0);
    drive(25'h307FF, 8'hE1);
    step();
    ioctl_wr = 1'b0;
    check("prom.last", 32'(prom_addr), 32'h7FF);
    drive(25'h30800, 8'h05);
    step();
    ioctl_wr = 1'b0;
    check("drop.prom", 32'(prom_we), 32'd0);
    check("drop.sdram", 32'(prog_we), 32'd0);

    // Back-pressure and overflow
    for (int i = 0; i < 5; i++) begin
      drive(25'h100 + 25'(2 * i), 8'hA0 + 8'(i));
      if (i < 4) expect_push(25'h100 + 25'(2 * i), 8'hA0 + 8'(i));
      step();
      if (i < 4) check("bp.wait", 32'(ioctl_wait), (i >= 2) ? 32'd1 : 32'd0);
    end
    ioctl_wr = 1'b0;
    check("bp.ovf", 32'(overflow), 32'd1);
    check("bp.wait_full", 32'(ioctl_wait), 32'd1);
    for (int i = 0; i < 4; i++) ack_head("bp");
    check("bp.drained", 32'(prog_we), 32'd0);
    check("bp.wait_clr", 32'(ioctl_wait), 32'd0);
    check("bp.ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop at count 2
    drive(25'h200, 8'h31);
    expect_push(25'h200, 8'h31);
    step();
    drive(25'h203, 8'h32);
    expect_push(25'h203, 8'h32);
    step();
    drive(25'h28005, 8'h33);
    expect_push(25'h28005, 8'h33);
    ack_head("pp0");
    ioctl_wr = 1'b0;
    check("pp.wait", 32'(ioctl_wait), 32'd0);
    ack_head("pp1");
    ack_head("pp2");
    check("pp.empty", 32'(prog_we), 32'd0);

    // Done fires at once when already empty; rising edge clears overflow
    downloading = 1'b0;
    step();
    check("done.imm", 32'(dwn_done), 32'd1);
    step();
    check("done.imm_pulse", 32'(dwn_done), 32'd0);
    downloading = 1'b1;
    step();
    check("ovf.rise_clr", 32'(overflow), 32'd0);

    // Drain with two pending entries
    drive(25'h300, 8'h44);
    expect_push(25'h300, 8'h44);
    step();
    drive(25'h301, 8'h55);
    expect_push(25'h301, 8'h55);
    step();
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    step();
    check("drain.armed", 32'(dwn_done), 32'd0);
    ack_head("drain0");
    check("drain.mid", 32'(dwn_done), 32'd0);
    ack_head("drain1");
    check("drain.done", 32'(dwn_done), 32'd1);
    step();
    check("drain.once", 32'(dwn_done), 32'd0);

    // Rising edge before drain disarms
    downloading = 1'b1;
    step();
    drive(25'h302, 8'h66);
    expect_push(25'h302, 8'h66);
    step();
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    step();
    downloading = 1'b1;
    step();
    ack_head("disarm");
    check("disarm.done", 32'(dwn_done), 32'd0);
    step();
    check("disarm.done2", 32'(dwn_done), 32'd0);

    // Reset mid-session discards entries
    drive(25'h304, 8'h77);
    step();
    drive(25'h306, 8'h88);
    step();
    ioctl_wr = 1'b0;
    check("rstmid.pre", 32'(prog_we), 32'd1);
    rst = 1'b1;
    step();
    check("rstmid.we", 32'(prog_we), 32'd0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmid.done", 32'(dwn_done), 32'd0);
      check("rstmid.we_hold", 32'(prog_we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
